// File: rtl/processor_pkg.sv
// Shared run-controller types and defaults for the Final_System core supervisor.
// Holds the run-state encoding and the default counter width and watchdog limit.
package processor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } run_state_e;

    localparam int CNT_WIDTH_DEF      = 16;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/core_finish_tracker.sv
// Per-core end-of-operation latch: a sticky seen flag plus the run cycle it was first seen.
module core_finish_tracker #(
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_i,
    input  logic                 endop_i,
    input  logic                 clear_i,
    input  logic                 run_i,
    input  logic [cnt_width-1:0] count_i,
    output logic                 seen_o,
    output logic [cnt_width-1:0] finish_o
);

    logic                 seen_q, seen_d;
    logic [cnt_width-1:0] finish_q, finish_d;

    always_comb begin
        // NOTE: hold values are assigned first so every path drives both signals; no latch.
        seen_d   = seen_q;
        finish_d = finish_q;
        if (clear_i) begin
            seen_d   = 1'b0;
            finish_d = '0;
        end else if (run_i && enable_i && endop_i && !seen_q) begin
            seen_d   = 1'b1;
            finish_d = count_i;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_q   <= 1'b0;
            finish_q <= '0;
        end else begin
            seen_q   <= seen_d;
            finish_q <= finish_d;
        end
    end

    assign seen_o   = seen_q;
    assign finish_o = finish_q;

endmodule

// File: rtl/core_run_controller.sv
// Launches a run on the enabled cores, latches their end-of-operation and reports done.
// Optional watchdog: define RUN_TIMEOUT_EN to enable the TIMEOUT state.
module core_run_controller
    import processor_pkg::*;
#(
    parameter int core_count     = 3,
    parameter int cnt_width      = CNT_WIDTH_DEF,
    parameter int timeout_cycles = TIMEOUT_CYCLES_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [core_count-1:0]           core_enable,
    input  logic [core_count-1:0]           endop_signal,
    output logic [core_count-1:0]           core_start,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout,
    output logic [core_count-1:0]           pending_mask,
    output logic [cnt_width-1:0]            total_cycles,
    output logic [core_count*cnt_width-1:0] finish_cycles
);

    run_state_e            state_q, state_d;
    logic [core_count-1:0] enable_q, enable_d;
    logic [core_count-1:0] seen_q;
    logic [cnt_width-1:0]  total_q, total_d;
    logic [cnt_width-1:0]  cnt_next;
    logic                  clear;
    logic                  in_run;
    logic                  all_done;

`ifdef RUN_TIMEOUT_EN
    localparam logic [cnt_width-1:0] TIMEOUT_LIMIT = cnt_width'(timeout_cycles);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (timeout_cycles > 0);
`endif

    assign cnt_next = (&total_q) ? total_q : total_q + 1'b1;
    assign in_run   = (state_q == ST_RUN);
    // Cores finishing on this edge count as seen for the completion decision.
    assign all_done = ((enable_q & ~seen_q & ~endop_signal) == '0);

    always_comb begin
        state_d  = state_q;
        enable_d = enable_q;
        total_d  = total_q;
        clear    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    clear    = 1'b1;
                    enable_d = core_enable;
                    total_d  = '0;
                    state_d  = (core_enable == '0) ? ST_DONE : ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN: begin
                total_d = cnt_next;
                if (all_done) begin
                    state_d = ST_DONE;
                end
`ifdef RUN_TIMEOUT_EN
                else if (cnt_next == TIMEOUT_LIMIT) begin
                    state_d = ST_TIMEOUT;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            enable_q <= '0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            total_q  <= total_d;
        end
    end

    for (genvar i = 0; i < core_count; i++) begin : g_core
        core_finish_tracker #(
            .cnt_width(cnt_width)
        ) u_tracker (
            .clk      (clk),
            .reset    (reset),
            .enable_i (enable_q[i]),
            .endop_i  (endop_signal[i]),
            .clear_i  (clear),
            .run_i    (in_run),
            .count_i  (cnt_next),
            .seen_o   (seen_q[i]),
            .finish_o (finish_cycles[i*cnt_width +: cnt_width])
        );
    end

    // Outputs decode registered state only, so nothing combinational reaches them from inputs.
    assign core_start   = (state_q == ST_LAUNCH) ? enable_q : '0;
    assign busy         = (state_q == ST_LAUNCH) || (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign pending_mask = enable_q & ~seen_q;
    assign total_cycles = total_q;
`ifdef RUN_TIMEOUT_EN
    assign timeout      = (state_q == ST_TIMEOUT);
`else
    assign timeout      = 1'b0;
`endif

endmodule
